// File: rtl/pwm_ctrl_pkg.sv
// Shared constants and types for the PWM duty-ramp controller: register map,
// CTRL bit positions and the channel state enum.
package pwm_ctrl_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_TARGET = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_STEP   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd3;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_RAMPING = 1;
    localparam int unsigned CTRL_RUNNING = 2;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Avalon-MM slave bus used by the Nios II to program one PWM channel.
interface pwm_duty_ramp_ctrl_if;
    import pwm_ctrl_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pwm_ramp_step.sv
// Slew-limited step of the live duty towards the target; never overshoots.
module pwm_ramp_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_target,
    input  logic [WIDTH-1:0] i_step,
    output logic [WIDTH-1:0] o_next_c
);
    localparam int unsigned DW = WIDTH + 1;

    logic signed [DW-1:0] w_diff;
    logic        [DW-1:0] w_mag;
    logic                 w_limited;

    // One extra bit keeps the full +/- range of target - d representable.
    assign w_diff    = $signed({1'b0, i_target}) - $signed({1'b0, i_d});
    assign w_mag     = w_diff[DW-1] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_limited = (i_step != '0) && (w_mag > {1'b0, i_step});

    always_comb begin
        o_next_c = i_target;
        if (w_limited) begin
            if (w_diff[DW-1]) begin
                o_next_c = i_d - i_step;
            end else begin
                o_next_c = i_d + i_step;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// One PWM channel with an Avalon-MM register file and per-period duty ramping.
// Register changes reach the waveform only at period wrap, so pulses are never truncated.
module pwm_duty_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PERIOD_RST = 49999
) (
    input  logic                clk,
    input  logic                reset,
    pwm_duty_ramp_ctrl_if.slave bus,
    output logic                pwm_out,
    output logic [WIDTH-1:0]    duty_active,
    output logic                period_tick
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_step;
    logic             r_enable;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period_sh;
    logic [WIDTH-1:0] r_duty;
    logic             r_pwm;
    logic             r_tick;

    logic             w_wr;
    logic             w_run;
    logic             w_wrap;
    logic [WIDTH-1:0] w_ramp_d;
    logic [WIDTH-1:0] w_ramp_c;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_psh_nxt;
    logic [WIDTH-1:0] w_duty_nxt;
    logic             w_pwm_nxt;
    logic             w_tick_nxt;
    logic [DATA_W-1:0] w_readdata_c;

    assign w_wr   = bus.chipselect && !bus.write_n;
    assign w_run  = (r_state == RUN);
    assign w_wrap = w_run && (r_cnt == r_period_sh);

    generate
        if (WIDTH < DATA_W) begin : g_wdata_hi
            logic w_unused_wdata_hi;
            assign w_unused_wdata_hi = ^bus.writedata[DATA_W-1:WIDTH];
        end
    endgenerate

    // Register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target <= '0;
            r_period <= WIDTH'(PERIOD_RST);
            r_step   <= '0;
            r_enable <= 1'b0;
        end else if (w_wr) begin
            case (bus.address)
                ADDR_TARGET: r_target <= bus.writedata[WIDTH-1:0];
                ADDR_PERIOD: r_period <= bus.writedata[WIDTH-1:0];
                ADDR_STEP:   r_step   <= bus.writedata[WIDTH-1:0];
                ADDR_CTRL:   r_enable <= bus.writedata[CTRL_EN];
                default: ;
            endcase
        end
    end

    // A channel starting from OFF ramps away from zero, not from a stale duty.
    assign w_ramp_d = w_run ? r_duty : '0;

    pwm_ramp_step #(
        .WIDTH(WIDTH)
    ) u_ramp (
        .i_d      (w_ramp_d),
        .i_target (r_target),
        .i_step   (r_step),
        .o_next_c (w_ramp_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OFF: begin
                if (r_enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_wrap && !r_enable) begin
                    w_state_nxt = OFF;
                end
            end
            default: w_state_nxt = OFF;
        endcase
    end

    // FSM outputs: next counter, shadow period, duty and waveform values
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_psh_nxt  = r_period_sh;
        w_duty_nxt = r_duty;
        case (r_state)
            OFF: begin
                w_cnt_nxt  = '0;
                w_duty_nxt = '0;
                if (r_enable) begin
                    w_psh_nxt  = r_period;
                    w_duty_nxt = w_ramp_c;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_enable) begin
                        w_psh_nxt  = r_period;
                        w_duty_nxt = w_ramp_c;
                    end else begin
                        w_duty_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + WIDTH'(1);
                end
            end
            default: begin
                w_cnt_nxt  = '0;
                w_duty_nxt = '0;
            end
        endcase
        w_pwm_nxt  = w_run && (r_cnt < r_duty);
        // Tick is registered one cycle ahead so it is high exactly while cnt == period_sh.
        w_tick_nxt = (w_state_nxt == RUN) && (w_cnt_nxt == w_psh_nxt);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_period_sh <= WIDTH'(PERIOD_RST);
            r_duty      <= '0;
            r_pwm       <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_period_sh <= w_psh_nxt;
            r_duty      <= w_duty_nxt;
            r_pwm       <= w_pwm_nxt;
            r_tick      <= w_tick_nxt;
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        w_readdata_c = '0;
        case (bus.address)
            ADDR_TARGET: w_readdata_c[WIDTH-1:0] = r_target;
            ADDR_PERIOD: w_readdata_c[WIDTH-1:0] = r_period;
            ADDR_STEP:   w_readdata_c[WIDTH-1:0] = r_step;
            ADDR_CTRL: begin
                w_readdata_c[CTRL_EN]      = r_enable;
                w_readdata_c[CTRL_RAMPING] = w_run && (r_duty != r_target);
                w_readdata_c[CTRL_RUNNING] = w_run;
            end
            default: w_readdata_c = '0;
        endcase
    end

    assign bus.readdata = w_readdata_c;
    assign pwm_out      = r_pwm;
    assign duty_active  = r_duty;
    assign period_tick  = r_tick;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Self-checking bench for pwm_duty_ramp_ctrl: period-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_pwm_duty_ramp_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned PERIOD_RST = 49999;

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             reset;
    logic             pwm_out;
    logic [WIDTH-1:0] duty_active;
    logic             period_tick;

    int checks = 0;
    int errors = 0;

    pwm_duty_ramp_ctrl_if bus();

    pwm_duty_ramp_ctrl #(
        .WIDTH      (WIDTH),
        .PERIOD_RST (PERIOD_RST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .pwm_out     (pwm_out),
        .duty_active (duty_active),
        .period_tick (period_tick)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers, running flag, position in period, period length, duty.
    int m_target, m_period, m_step;
    bit m_en, m_run, m_pwm;
    int m_pos, m_len, m_duty;

    function automatic int ramp(input int d);
        int diff;
        diff = m_target - d;
        if (m_step == 0) return m_target;
        if (diff > m_step) return d + m_step;
        if (diff < -m_step) return d - m_step;
        return m_target;
    endfunction

    function automatic int exp_read(input logic [1:0] a);
        case (a)
            ADDR_TARGET: return m_target;
            ADDR_PERIOD: return m_period;
            ADDR_STEP:   return m_step;
            default:     return (m_run ? 4 : 0) + ((m_run && m_duty != m_target) ? 2 : 0)
                                + (m_en ? 1 : 0);
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_target = 0; m_period = PERIOD_RST; m_step = 0; m_en = 0;
            m_run = 0; m_pos = 0; m_len = 1; m_duty = 0; m_pwm = 0;
        end else begin
            m_pwm = m_run && (m_pos < m_duty);
            if (!m_run) begin
                if (m_en) begin
                    m_run = 1; m_pos = 0; m_len = m_period + 1; m_duty = ramp(0);
                end
            end else if (m_pos == m_len - 1) begin
                m_pos = 0;
                if (m_en) begin
                    m_len = m_period + 1; m_duty = ramp(m_duty);
                end else begin
                    m_run = 0; m_duty = 0;
                end
            end else begin
                m_pos++;
            end
            if (bus.chipselect && !bus.write_n) begin
                case (bus.address)
                    ADDR_TARGET: m_target = int'(bus.writedata[15:0]);
                    ADDR_PERIOD: m_period = int'(bus.writedata[15:0]);
                    ADDR_STEP:   m_step   = int'(bus.writedata[15:0]);
                    default:     m_en     = bus.writedata[0];
                endcase
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("pwm_out", int'(pwm_out), int'(m_pwm));
            chk("period_tick", int'(period_tick), int'(m_run && (m_pos == m_len - 1)));
            chk("duty_active", int'(duty_active), m_duty);
            chk("readdata", int'(bus.readdata), exp_read(bus.address));
        end
    end

    task automatic wr(input logic [1:0] a, input int d);
        bus.address = a; bus.writedata = 32'(d); bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output int v);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        v = int'(bus.readdata);
        bus.chipselect = 1'b0;
    endtask

    task automatic to_tick(output int n);
        n = 0;
        while (!period_tick && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!period_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic next_period_duty(output int d);
        int n;
        to_tick(n);
        @(posedge clk); #1;
        d = int'(duty_active);
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(m_run && m_pos == p) && n < 500);
        if (!(m_run && m_pos == p)) chk("wait_pos_timeout", 0, 1);
    endtask

    initial begin
        int v, n, hi;
        reset = 1'b1;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

        // Reset state with no clock running
        #2;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_duty", int'(duty_active), 0);
        chk("rst_tick", int'(period_tick), 0);
        rd(ADDR_PERIOD, v); chk("rst_period", v, 49999);
        rd(ADDR_CTRL, v);   chk("rst_ctrl", v, 0);
        rd(ADDR_TARGET, v); chk("rst_target", v, 0);
        #10 reset = 1'b0;
        #10 clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Fixed duty 4 in a 10-cycle period
        wr(ADDR_PERIOD, 9); wr(ADDR_STEP, 0); wr(ADDR_TARGET, 4); wr(ADDR_CTRL, 1);
        chk("start_pwm_e0", int'(pwm_out), 0);
        @(posedge clk); #1;
        chk("start_pwm_e1", int'(pwm_out), 0);
        chk("start_duty", int'(duty_active), 4);
        @(posedge clk); #1;
        chk("start_pwm_e2", int'(pwm_out), 1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            hi += int'(pwm_out); @(posedge clk); #1;
        end
        chk("high_cycles_4", hi, 4);
        to_tick(n);
        @(posedge clk); #1; to_tick(n);
        chk("period_len_10", n + 1, 10);
        rd(ADDR_CTRL, v); chk("ctrl_run", v, 5);

        // Disable, then ramp 0 -> 7 with step 2, then back to 1
        wr(ADDR_CTRL, 0);
        to_tick(n);
        @(posedge clk); #1;
        rd(ADDR_CTRL, v); chk("ctrl_off", v, 0);
        wr(ADDR_STEP, 2); wr(ADDR_TARGET, 7); wr(ADDR_CTRL, 1);
        @(posedge clk); #1;
        chk("ramp_up_0", int'(duty_active), 2);
        rd(ADDR_CTRL, v); chk("ctrl_ramping", v, 7);
        next_period_duty(v); chk("ramp_up_1", v, 4);
        next_period_duty(v); chk("ramp_up_2", v, 6);
        next_period_duty(v); chk("ramp_up_3", v, 7);
        rd(ADDR_CTRL, v); chk("ctrl_settled", v, 5);
        wr(ADDR_TARGET, 1);
        next_period_duty(v); chk("ramp_dn_1", v, 5);
        next_period_duty(v); chk("ramp_dn_2", v, 3);
        next_period_duty(v); chk("ramp_dn_3", v, 1);

        // PERIOD write mid-period, TARGET write on the wrap cycle
        wait_pos(3);
        wr(ADDR_PERIOD, 4);
        to_tick(n); chk("old_period_completes", n, 5);
        @(posedge clk); #1; to_tick(n); chk("new_period_len_a", n + 1, 5);
        @(posedge clk); #1; to_tick(n); chk("new_period_len_b", n + 1, 5);
        wr(ADDR_STEP, 0);
        to_tick(n);
        wr(ADDR_TARGET, 3);
        chk("wrap_write_unseen", int'(duty_active), 1);
        next_period_duty(v); chk("wrap_write_later", v, 3);

        // Duty above period: constant high; duty 0: constant low
        wr(ADDR_PERIOD, 9); wr(ADDR_TARGET, 20);
        next_period_duty(v); chk("duty_20", v, 20);
        @(posedge clk); #1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            hi += int'(pwm_out); @(posedge clk); #1;
        end
        chk("const_high", hi, 20);
        rd(ADDR_CTRL, v); chk("ctrl_const_high", v, 5);
        wait_pos(0);
        wr(ADDR_TARGET, 0);
        next_period_duty(v); chk("duty_0", v, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; hi += int'(pwm_out);
        end
        chk("const_low", hi, 0);

        // Disable at cnt=2 with duty 4: pulse and period complete, then OFF
        wait_pos(0);
        wr(ADDR_TARGET, 4);
        next_period_duty(v); chk("duty_4", v, 4);
        wait_pos(2);
        wr(ADDR_CTRL, 0);
        chk("pulse_continues", int'(pwm_out), 1);
        to_tick(n); chk("disable_period_completes", n, 6);
        chk("pwm_at_last_wrap", int'(pwm_out), 0);
        @(posedge clk); #1;
        chk("off_duty", int'(duty_active), 0);
        rd(ADDR_CTRL, v); chk("off_ctrl", v, 0);

        // Asynchronous reset during a high pulse
        wr(ADDR_CTRL, 1);
        n = 0;
        while (!pwm_out && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("pulse_seen", int'(pwm_out), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_duty", int'(duty_active), 0);
        rd(ADDR_PERIOD, v); chk("async_rst_period", v, 49999);
        rd(ADDR_TARGET, v); chk("async_rst_target", v, 0);
        rd(ADDR_CTRL, v);   chk("async_rst_ctrl", v, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_pwm", int'(pwm_out), 0);
        rd(ADDR_STEP, v); chk("post_rst_step", v, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
